// File: rtl/team_id_commit_ctrl_pkg.sv
// Package for the Team ID commit controller.
// Holds the FSM state type (encodings are software-visible in STATUS[2:0]),
// the register offsets, the CTRL bit positions and the default unlock keys.
package team_id_commit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY1      = 3'd1,
        ST_ARMED     = 3'd2,
        ST_HANDSHAKE = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    localparam logic [2:0] OFF_STAGE  = 3'h0;
    localparam logic [2:0] OFF_KEY    = 3'h2;
    localparam logic [2:0] OFF_CTRL   = 3'h4;
    localparam logic [2:0] OFF_STATUS = 3'h6;

    localparam int unsigned CTRL_COMMIT = 0;
    localparam int unsigned CTRL_ABORT  = 1;

    localparam logic [15:0] DEF_KEY1 = 16'hA55A;
    localparam logic [15:0] DEF_KEY2 = 16'h5AA5;

endpackage

// File: rtl/team_id_commit_ctrl_if.sv
// Bus and app-side handshake bundle for team_id_commit_ctrl.
// slave  : the peripheral (receives the openMSP430 bus and team_id_ack,
//          drives read data and the Team ID outputs).
// master : the CPU/app side (drives the bus and ack, observes the outputs).
interface team_id_commit_ctrl_if;

    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        team_id_ack;
    logic [15:0] team_id_out;
    logic        team_id_valid;
    logic        team_id_req;
    logic        team_id_irq;

    modport slave (
        input  per_addr, per_din, per_en, per_we, team_id_ack,
        output per_dout, team_id_out, team_id_valid, team_id_req, team_id_irq
    );

    modport master (
        output per_addr, per_din, per_en, per_we, team_id_ack,
        input  per_dout, team_id_out, team_id_valid, team_id_req, team_id_irq
    );

endinterface

// File: rtl/team_id_timer.sv
// 16-bit loadable down-counter shared by the arm and ack timeouts.
// Ports: mclk/puc_rst clock and async reset; load/value reload the count;
// tick decrements (stops at 0); expired is high while the count is 0.
module team_id_timer (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        tick,
    output logic        expired
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/team_id_commit_ctrl.sv
// Team ID commit controller: openMSP430 peripheral that releases a staged
// 16-bit ID to the app processor after a two-word unlock and a commit,
// completes a req/ack handshake, then locks until reset.
// Ports: mclk, puc_rst (async, active-high), smclk_en (arm-timeout tick),
// bus (slave side: per_* peripheral bus, team_id_ack in; per_dout,
// team_id_out/valid/req/irq out).
module team_id_commit_ctrl
    import team_id_commit_ctrl_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR   = 15'h01B8,
    parameter int unsigned DEC_WD      = 3,
    parameter logic [15:0] KEY1        = DEF_KEY1,
    parameter logic [15:0] KEY2        = DEF_KEY2,
    parameter logic [15:0] ARM_TIMEOUT = 16'd1000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd255,
    parameter logic [3:0]  MAX_FAIL    = 4'd3
) (
    input  logic                 mclk,
    input  logic                 puc_rst,
    input  logic                 smclk_en,
    team_id_commit_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [15:0] stage_q, stage_d;
    logic [3:0]  fail_q, fail_d;
    logic [15:0] out_q, out_d;
    logic        req_q, req_d;
    logic        irq_q, irq_d;

    logic        tmr_load, tmr_tick, tmr_expired;
    logic [15:0] tmr_val;

    // Address decode and write qualification
    logic              sel, wr_any, wr_word, rd;
    logic [DEC_WD-1:0] off;
    logic              stage_wr, key_wr, ctrl_wr, abort_wr, commit_wr, timeout, fail_evt;
    logic              valid;

    assign sel       = bus.per_en && (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign off       = {bus.per_addr[DEC_WD-2:0], 1'b0};
    assign wr_any    = sel && (bus.per_we != 2'b00);
    assign wr_word   = sel && (bus.per_we == 2'b11);
    assign rd        = sel && (bus.per_we == 2'b00);
    assign stage_wr  = wr_any  && (off == DEC_WD'(OFF_STAGE));
    assign key_wr    = wr_word && (off == DEC_WD'(OFF_KEY));
    assign ctrl_wr   = wr_word && (off == DEC_WD'(OFF_CTRL));
    assign abort_wr  = ctrl_wr && bus.per_din[CTRL_ABORT];
    assign commit_wr = ctrl_wr && bus.per_din[CTRL_COMMIT] && !bus.per_din[CTRL_ABORT];
    // Any write in the expiry cycle discards the arm timeout.
    assign timeout   = tmr_expired && !wr_any;
    assign valid     = (state_q == ST_LOCKED);

    team_id_timer u_timer (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .load    (tmr_load),
        .value   (tmr_val),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        fail_d   = fail_q;
        out_d    = out_q;
        req_d    = req_q;
        tmr_load = 1'b0;
        tmr_val  = ARM_TIMEOUT;
        tmr_tick = 1'b0;
        fail_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stage_wr && bus.per_we[0]) stage_d[7:0]  = bus.per_din[7:0];
                if (stage_wr && bus.per_we[1]) stage_d[15:8] = bus.per_din[15:8];
                if (key_wr) begin
                    if (bus.per_din == KEY1) begin
                        state_d  = ST_KEY1;
                        tmr_load = 1'b1;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end
            end
            ST_KEY1: begin
                tmr_tick = smclk_en;
                if (key_wr) begin
                    if (bus.per_din == KEY2) begin
                        state_d  = ST_ARMED;
                        tmr_load = 1'b1;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end else if (abort_wr) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    fail_evt = 1'b1;
                end
            end
            ST_ARMED: begin
                tmr_tick = smclk_en;
                if (abort_wr) begin
                    state_d = ST_IDLE;
                end else if (commit_wr) begin
                    state_d  = ST_HANDSHAKE;
                    out_d    = stage_q;
                    req_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = ACK_TIMEOUT;
                end else if (key_wr || timeout) begin
                    fail_evt = 1'b1;
                end
            end
            ST_HANDSHAKE: begin
                tmr_tick = 1'b1;
                // ack wins over a simultaneous ack timeout
                if (bus.team_id_ack) begin
                    state_d = ST_LOCKED;
                    req_d   = 1'b0;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                    req_d   = 1'b0;
                    out_d   = '0;
                end
            end
            default: ;
        endcase

        // All failure paths return to IDLE unless this failure saturates the count.
        if (fail_evt) begin
            if (({1'b0, fail_q} + 5'd1) >= {1'b0, MAX_FAIL}) begin
                fail_d  = MAX_FAIL;
                state_d = ST_FAULT;
                out_d   = '0;
            end else begin
                fail_d  = fail_q + 4'd1;
                state_d = ST_IDLE;
            end
        end

        irq_d = ((state_d == ST_LOCKED) || (state_d == ST_FAULT)) && (state_d != state_q);
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            fail_q  <= '0;
            out_q   <= '0;
            req_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            fail_q  <= fail_d;
            out_q   <= out_d;
            req_q   <= req_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        bus.per_dout = '0;
        if (rd) begin
            if (off == DEC_WD'(OFF_STAGE)) begin
                bus.per_dout = stage_q;
            end else if (off == DEC_WD'(OFF_STATUS)) begin
                bus.per_dout = {4'b0000, fail_q, 2'b00, req_q, valid, 1'b0, state_q};
            end
        end
    end

    assign bus.team_id_out   = out_q;
    assign bus.team_id_valid = valid;
    assign bus.team_id_req   = req_q;
    assign bus.team_id_irq   = irq_q;

endmodule

// File: tb/tb_team_id_commit_ctrl.sv
// Self-checking bench for team_id_commit_ctrl: directed scenarios followed by
// randomized register traffic, all compared cycle by cycle against a
// transaction-level reference model of the unlock/commit protocol.
module tb_team_id_commit_ctrl;

    localparam logic [15:0] K1     = 16'hA55A;
    localparam logic [15:0] K2     = 16'h5AA5;
    localparam int          ARM_TO = 1000;
    localparam int          ACK_TO = 255;
    localparam int          MAXF   = 3;
    localparam logic [13:0] WBASE  = 14'h00DC;   // byte base 0x01B8 as a word address

    localparam int S_IDLE = 0, S_KEY1 = 1, S_ARMED = 2, S_HS = 3, S_LOCKED = 4, S_FAULT = 5;

    logic mclk = 1'b0;
    logic puc_rst = 1'b0;
    logic smclk_en = 1'b0;

    team_id_commit_ctrl_if bus ();

    team_id_commit_ctrl #(
        .BASE_ADDR   (15'h01B8),
        .DEC_WD      (3),
        .KEY1        (K1),
        .KEY2        (K2),
        .ARM_TIMEOUT (16'd1000),
        .ACK_TIMEOUT (16'd255),
        .MAX_FAIL    (4'd3)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .smclk_en (smclk_en),
        .bus      (bus)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_state, m_fail, m_elapsed;
    logic [15:0] m_stage, m_out;
    logic        m_req, m_irq;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_fail = 0; m_elapsed = 0;
        m_stage = '0; m_out = '0; m_req = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [15:0] model_read();
        logic [15:0] r;
        int off;
        r = '0;
        off = int'(bus.per_addr[1:0]) * 2;
        if (bus.per_en && ((bus.per_addr >> 2) == (WBASE >> 2)) && bus.per_we == 2'b00) begin
            if (off == 0) r = m_stage;
            if (off == 6) begin
                r[2:0]  = 3'(m_state);
                r[4]    = (m_state == S_LOCKED);
                r[5]    = m_req;
                r[11:8] = 4'(m_fail);
            end
        end
        return r;
    endfunction

    // Apply the protocol rules for one rising edge to the model.
    task automatic model_edge();
        bit sel, wany, keyw, ctrlw, abort, commit, expired, fail, tick;
        int off, prev;
        logic [15:0] d;
        prev = m_state;
        d    = bus.per_din;
        off  = int'(bus.per_addr[1:0]) * 2;
        sel  = bus.per_en && ((bus.per_addr >> 2) == (WBASE >> 2));
        wany = sel && (bus.per_we != 2'b00);
        keyw  = sel && bus.per_we == 2'b11 && off == 2;
        ctrlw = sel && bus.per_we == 2'b11 && off == 4;
        abort  = ctrlw && d[1];
        commit = ctrlw && d[0] && !d[1];
        expired = (m_state == S_HS) ? (m_elapsed >= ACK_TO) : (m_elapsed >= ARM_TO);
        fail = 0;
        tick = (m_state == S_HS) || ((m_state == S_KEY1 || m_state == S_ARMED) && smclk_en);
        case (m_state)
            S_IDLE: begin
                if (wany && off == 0) begin
                    if (bus.per_we[0]) m_stage[7:0]  = d[7:0];
                    if (bus.per_we[1]) m_stage[15:8] = d[15:8];
                end
                if (keyw) begin
                    if (d == K1) begin m_state = S_KEY1; m_elapsed = 0; end
                    else fail = 1;
                end
            end
            S_KEY1: begin
                if (keyw) begin
                    if (d == K2) begin m_state = S_ARMED; m_elapsed = 0; end
                    else fail = 1;
                end else if (abort) m_state = S_IDLE;
                else if (expired && !wany) fail = 1;
            end
            S_ARMED: begin
                if (abort) m_state = S_IDLE;
                else if (commit) begin
                    m_state = S_HS; m_out = m_stage; m_req = 1'b1; m_elapsed = 0;
                end else if (keyw || (expired && !wany)) fail = 1;
            end
            S_HS: begin
                if (bus.team_id_ack) begin m_state = S_LOCKED; m_req = 1'b0; end
                else if (expired) begin m_state = S_FAULT; m_req = 1'b0; m_out = '0; end
            end
            default: ;
        endcase
        if (fail) begin
            if (m_fail + 1 >= MAXF) begin m_fail = MAXF; m_state = S_FAULT; m_out = '0; end
            else begin m_fail++; m_state = S_IDLE; end
        end
        if (m_state == prev && tick) m_elapsed++;
        m_irq = (m_state == S_LOCKED || m_state == S_FAULT) && (prev != m_state);
    endtask

    // One clock: check the combinational read, step the edge, check outputs.
    task automatic cycle();
        #1;
        chk("per_dout", bus.per_dout, model_read());
        @(posedge mclk);
        model_edge();
        #1;
        chk("team_id_out", bus.team_id_out, m_out);
        chk("team_id_valid", bus.team_id_valid, m_state == S_LOCKED);
        chk("team_id_req", bus.team_id_req, m_req);
        chk("team_id_irq", bus.team_id_irq, m_irq);
    endtask

    task automatic wr(input logic [2:0] off, input logic [1:0] we, input logic [15:0] d);
        bus.per_en = 1'b1; bus.per_addr = WBASE + 14'(off >> 1); bus.per_we = we; bus.per_din = d;
        cycle();
        bus.per_en = 1'b0; bus.per_we = 2'b00;
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [15:0] exp);
        bus.per_en = 1'b1; bus.per_addr = WBASE + 14'(off >> 1); bus.per_we = 2'b00;
        #1;
        chk(tag, bus.per_dout, exp);
        cycle();
        bus.per_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.per_en = 1'b0; bus.per_we = 2'b00;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = '0; bus.per_din = '0;
        bus.team_id_ack = 1'b0; smclk_en = 1'b0;
        puc_rst = 1'b1;
        #1;
        chk("rst_out", bus.team_id_out, 16'h0000);
        chk("rst_req", bus.team_id_req, 16'h0000);
        chk("rst_valid", bus.team_id_valid, 16'h0000);
        chk("rst_irq", bus.team_id_irq, 16'h0000);
        @(posedge mclk);
        #1;
        puc_rst = 1'b0;
        model_reset();
    endtask

    task automatic unlock_commit(input logic [15:0] id);
        wr(3'h0, 2'b11, id);
        wr(3'h2, 2'b11, K1);
        wr(3'h2, 2'b11, K2);
        wr(3'h4, 2'b11, 16'h0001);
    endtask

    task automatic wait_arm_expiry(input string tag);
        int n = 0;
        while (m_elapsed < ARM_TO && n < 10000) begin
            smclk_en = 1'($urandom_range(0, 1));
            idle(1);
            n++;
        end
        smclk_en = 1'b0;
        if (n >= 10000) begin
            checks++; errors++;
            $error("FAIL %s observed=timeout expected=arm expiry", tag);
        end
    endtask

    initial begin
        model_reset();
        bus.team_id_ack = 1'b0;
        do_reset();
        rd("status_reset", 3'h6, 16'h0000);

        // Byte lanes of STAGE and unselected read
        wr(3'h0, 2'b11, 16'hFFFF);
        wr(3'h0, 2'b01, 16'h0034);
        wr(3'h0, 2'b10, 16'h12AB);
        rd("stage_bytes", 3'h0, 16'h1234);
        bus.per_en = 1'b1; bus.per_addr = WBASE + 14'd4; bus.per_we = 2'b00;
        #1;
        chk("unselected_read", bus.per_dout, 16'h0000);
        idle(1);

        // Byte KEY write ignored; CTRL with both bits aborts
        wr(3'h2, 2'b01, K1);
        rd("key_byte_ignored", 3'h6, 16'h0000);
        wr(3'h2, 2'b11, K1);
        wr(3'h4, 2'b11, 16'h0003);
        rd("abort_wins", 3'h6, 16'h0000);

        // Successful commit with ack two cycles after req
        unlock_commit(16'h1234);
        chk("req_on_commit", bus.team_id_req, 16'h0001);
        chk("out_on_commit", bus.team_id_out, 16'h1234);
        idle(1);
        bus.team_id_ack = 1'b1;
        idle(1);
        bus.team_id_ack = 1'b0;
        chk("locked_valid", bus.team_id_valid, 16'h0001);
        chk("locked_irq", bus.team_id_irq, 16'h0001);
        idle(1);
        chk("irq_one_cycle", bus.team_id_irq, 16'h0000);
        rd("status_locked", 3'h6, 16'h0014);

        // LOCKED ignores further staging and commits
        unlock_commit(16'hBEEF);
        idle(3);
        chk("locked_out_kept", bus.team_id_out, 16'h1234);
        rd("status_locked2", 3'h6, 16'h0014);

        // Three bad keys -> FAULT
        do_reset();
        wr(3'h2, 2'b11, 16'h0000);
        rd("fail1", 3'h6, 16'h0100);
        wr(3'h2, 2'b11, 16'h0000);
        rd("fail2", 3'h6, 16'h0200);
        wr(3'h2, 2'b11, 16'h0000);
        chk("fault_irq", bus.team_id_irq, 16'h0001);
        rd("fault_status", 3'h6, 16'h0305);
        unlock_commit(16'h4321);
        rd("fault_sticky", 3'h6, 16'h0305);

        // Arm timeout in ARMED
        do_reset();
        wr(3'h2, 2'b11, K1);
        wr(3'h2, 2'b11, K2);
        wait_arm_expiry("arm_wait1");
        idle(1);
        rd("arm_timeout", 3'h6, 16'h0100);

        // Write on the expiry cycle wins: KEY2 in KEY1, then ABORT in ARMED
        do_reset();
        wr(3'h2, 2'b11, K1);
        wait_arm_expiry("arm_wait2");
        wr(3'h2, 2'b11, K2);
        rd("key_beats_timeout", 3'h6, 16'h0002);
        wait_arm_expiry("arm_wait3");
        wr(3'h4, 2'b11, 16'h0002);
        rd("abort_beats_timeout", 3'h6, 16'h0000);

        // Ack timeout -> FAULT
        do_reset();
        unlock_commit(16'h55AA);
        idle(ACK_TO);
        chk("req_before_timeout", bus.team_id_req, 16'h0001);
        idle(1);
        chk("ack_to_req", bus.team_id_req, 16'h0000);
        chk("ack_to_out", bus.team_id_out, 16'h0000);
        rd("ack_to_status", 3'h6, 16'h0005);

        // Ack on the timeout cycle still locks
        do_reset();
        unlock_commit(16'h0F0F);
        idle(ACK_TO);
        bus.team_id_ack = 1'b1;
        idle(1);
        bus.team_id_ack = 1'b0;
        rd("ack_at_timeout", 3'h6, 16'h0014);

        // Reset mid-handshake, then a clean run
        do_reset();
        unlock_commit(16'hCAFE);
        idle(3);
        do_reset();
        unlock_commit(16'hCAFE);
        bus.team_id_ack = 1'b1;
        idle(1);
        bus.team_id_ack = 1'b0;
        chk("post_rst_out", bus.team_id_out, 16'hCAFE);
        rd("post_rst_status", 3'h6, 16'h0014);

        // Randomized traffic against the model
        for (int ep = 0; ep < 15; ep++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                int unsigned r;
                r = $urandom_range(0, 15);
                bus.team_id_ack = ($urandom_range(0, 3) == 0);
                smclk_en = 1'($urandom_range(0, 1));
                bus.per_en = 1'b1; bus.per_we = 2'b11; bus.per_din = 16'($urandom);
                bus.per_addr = WBASE + 14'($urandom_range(0, 3));
                case (r)
                    0, 1, 2, 3: bus.per_en = 1'b0;
                    4:      begin bus.per_addr = WBASE; bus.per_we = 2'($urandom_range(1, 3)); end
                    5, 6:   begin bus.per_addr = WBASE + 14'd1; bus.per_din = K1; end
                    7, 8:   begin bus.per_addr = WBASE + 14'd1; bus.per_din = K2; end
                    9:      bus.per_addr = WBASE + 14'd1;
                    10:     begin bus.per_addr = WBASE + 14'd2; bus.per_din = 16'h0001; end
                    11:     begin bus.per_addr = WBASE + 14'd2; bus.per_din = 16'h0002; end
                    12:     bus.per_addr = WBASE + 14'd2;
                    13:     bus.per_we = 2'($urandom_range(1, 2));
                    14:     bus.per_we = 2'b00;
                    default: bus.per_addr = 14'($urandom);
                endcase
                cycle();
            end
            bus.per_en = 1'b0;
            bus.team_id_ack = 1'b0;
            rd("rand_status", 3'h6, model_read_status());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [15:0] model_read_status();
        logic [15:0] r;
        r = '0;
        r[2:0]  = 3'(m_state);
        r[4]    = (m_state == S_LOCKED);
        r[5]    = m_req;
        r[11:8] = 4'(m_fail);
        return r;
    endfunction

endmodule
